// File: rtl/arb_mux_4_1.sv
// arb_mux_4_1: four-source round-robin arbiter feeding one registered output stage.
// A source is accepted when its vld bit wins arbitration and the output register
// is empty or draining. The accepted word appears on y one cycle later, and
// sel records which source produced it. cnt counts accepted words modulo 256.
module arb_mux_4_1 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [3:0]       vld,
    output logic [3:0]       rdy,
    output logic [WIDTH-1:0] y,
    output logic [1:0]       sel,
    output logic             y_vld,
    input  logic             y_rdy,
    output logic [7:0]       cnt
);

    // Architectural state
    logic [WIDTH-1:0] r_y;
    logic [1:0]       r_sel;
    logic             r_y_vld;
    logic [1:0]       r_ptr;
    logic [7:0]       r_cnt;

    // Arbitration and datapath nets
    logic [7:0]       w_vld_dbl;
    logic [3:0]       w_rot;
    logic [1:0]       w_off;
    logic [1:0]       w_gnt;
    logic             w_any;
    logic             w_load;
    logic             w_take;
    logic [WIDTH-1:0] w_mux;

    // Rotate vld so that bit 0 is the current highest-priority source, then find the first requester
    always_comb begin
        w_vld_dbl = {vld, vld};
        w_rot     = w_vld_dbl[r_ptr +: 4];
        w_off     = 2'd0;
        casez (w_rot)
            4'b???1: w_off = 2'd0;
            4'b??10: w_off = 2'd1;
            4'b?100: w_off = 2'd2;
            4'b1000: w_off = 2'd3;
            default: w_off = 2'd0;
        endcase
        w_gnt  = r_ptr + w_off;
        w_any  = |vld;
        w_load = !r_y_vld || y_rdy;
        w_take = w_load && w_any && !rst;
    end

    // Select the granted source's word; bits are forwarded untouched
    always_comb begin
        w_mux = d0;
        case (w_gnt)
            2'd0:    w_mux = d0;
            2'd1:    w_mux = d1;
            2'd2:    w_mux = d2;
            2'd3:    w_mux = d3;
            default: w_mux = d0;
        endcase
    end

    // One-hot acceptance strobe back to the winning source; silent during reset or stall
    always_comb begin
        rdy = 4'b0000;
        if (w_take) begin
            rdy = 4'b0001 << w_gnt;
        end else begin
            rdy = 4'b0000;
        end
    end

    // Output register, pointer and accepted-word counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y     <= {WIDTH{1'b0}};
            r_sel   <= 2'd0;
            r_y_vld <= 1'b0;
            r_ptr   <= 2'd0;
            r_cnt   <= 8'd0;
        end else if (w_load) begin
            if (w_any) begin
                r_y     <= w_mux;
                r_sel   <= w_gnt;
                r_y_vld <= 1'b1;
                r_ptr   <= w_gnt + 2'd1;
                r_cnt   <= r_cnt + 8'd1;
            end else begin
                r_y_vld <= 1'b0;
            end
        end
    end

    assign y     = r_y;
    assign sel   = r_sel;
    assign y_vld = r_y_vld;
    assign cnt   = r_cnt;

endmodule
